// File: rtl/hazard_pkg.sv
// Shared types and helpers for the scoreboard hazard unit.
// Holds the multiply/divide op encoding and Tnew arithmetic.
package hazard_pkg;

  localparam int TW_DEF = 2;

  typedef enum logic [1:0] {
    MD_NONE = 2'd0,
    MD_MULT = 2'd1,
    MD_DIV  = 2'd2,
    MD_HILO = 2'd3
  } md_op_e;

  function automatic logic [TW_DEF-1:0] sat_dec(
    input logic [TW_DEF-1:0] t
  );
    return (t == '0) ? '0 : t - 1'b1;
  endfunction

endpackage

// File: rtl/md_busy_ctr.sv
// Multiply/divide busy counter: loads a latency, counts down to 0.
// Busy while non-zero.
module md_busy_ctr #(
  parameter int CW = 4
)(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_i,
  input  logic [CW-1:0] load_val_i,
  output logic          busy_o
);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign busy_o = (cnt_q != '0);

endmodule

// File: rtl/hazard_sb.sv
// Scoreboard hazard unit: tracks E/M/W destination tags internally
// and derives stall and operand forwarding selects from them.
module hazard_sb
  import hazard_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int TW       = TW_DEF,
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10,
  parameter int CW       = 4
)(
  input  logic            clk,
  input  logic            reset,
  input  logic [4:0]      D_rs_a,
  input  logic [4:0]      D_rt_a,
  input  logic [TW-1:0]   D_rs_tuse,
  input  logic [TW-1:0]   D_rt_tuse,
  input  logic [4:0]      D_wa,
  input  logic [TW-1:0]   D_tnew,
  input  logic [1:0]      D_md_op,
  input  logic [4:0]      E_rs_a,
  input  logic [4:0]      E_rt_a,
  input  logic [4:0]      M_rt_a,
  input  logic [XLEN-1:0] D_rs_o,
  input  logic [XLEN-1:0] D_rt_o,
  input  logic [XLEN-1:0] E_rs_o,
  input  logic [XLEN-1:0] E_rt_o,
  input  logic [XLEN-1:0] M_rt_o,
  input  logic [XLEN-1:0] E_wd,
  input  logic [XLEN-1:0] M_wd,
  input  logic [XLEN-1:0] W_wd,
  output logic [XLEN-1:0] D_rs_m,
  output logic [XLEN-1:0] D_rt_m,
  output logic [XLEN-1:0] E_rs_m,
  output logic [XLEN-1:0] E_rt_m,
  output logic [XLEN-1:0] M_rt_m,
  output logic            stall,
  output logic [4:0]      E_ad,
  output logic [4:0]      M_ad,
  output logic [4:0]      W_ad,
  output logic            md_busy
);

  logic [4:0]    e_wa_q, e_wa_d;
  logic [TW-1:0] e_tn_q, e_tn_d;
  logic [4:0]    m_wa_q, m_wa_d;
  logic [TW-1:0] m_tn_q, m_tn_d;
  logic [4:0]    w_wa_q, w_wa_d;

  logic          rs_st, rt_st, md_st;
  logic          md_load;
  logic [CW-1:0] md_val;

  function automatic logic src_stall(
    input logic [4:0]    a,
    input logic [TW-1:0] tuse
  );
    if (a == 5'd0) return 1'b0;
    return (e_wa_q == a && e_tn_q > tuse) ||
           (m_wa_q == a && m_tn_q > tuse);
  endfunction

  // Youngest matching stage wins; chk_e/chk_m drop stages
  // that are not younger than the consumer.
  function automatic logic [XLEN-1:0] fwd(
    input logic [4:0]      a,
    input logic            chk_e,
    input logic            chk_m,
    input logic [XLEN-1:0] raw
  );
    if (a == 5'd0) return '0;
    if (chk_e && e_wa_q == a) return E_wd;
    if (chk_m && m_wa_q == a) return M_wd;
    if (w_wa_q == a) return W_wd;
    return raw;
  endfunction

  always_comb begin
    rs_st  = src_stall(D_rs_a, D_rs_tuse);
    rt_st  = src_stall(D_rt_a, D_rt_tuse);
    md_st  = (D_md_op != MD_NONE) && md_busy;
    stall  = rs_st | rt_st | md_st;
    D_rs_m = fwd(D_rs_a, 1'b1, 1'b1, D_rs_o);
    D_rt_m = fwd(D_rt_a, 1'b1, 1'b1, D_rt_o);
    E_rs_m = fwd(E_rs_a, 1'b0, 1'b1, E_rs_o);
    E_rt_m = fwd(E_rt_a, 1'b0, 1'b1, E_rt_o);
    M_rt_m = fwd(M_rt_a, 1'b0, 1'b0, M_rt_o);
  end

  always_comb begin
    e_wa_d = stall ? 5'd0 : D_wa;
    e_tn_d = stall ? '0 : D_tnew;
    m_wa_d = e_wa_q;
    m_tn_d = sat_dec(e_tn_q);
    w_wa_d = m_wa_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      e_wa_q <= '0;
      e_tn_q <= '0;
      m_wa_q <= '0;
      m_tn_q <= '0;
      w_wa_q <= '0;
    end else begin
      e_wa_q <= e_wa_d;
      e_tn_q <= e_tn_d;
      m_wa_q <= m_wa_d;
      m_tn_q <= m_tn_d;
      w_wa_q <= w_wa_d;
    end
  end

  assign md_load = !stall &&
                   (D_md_op == MD_MULT || D_md_op == MD_DIV);
  assign md_val  = (D_md_op == MD_MULT) ? CW'(MULT_CYC)
                                        : CW'(DIV_CYC);

  md_busy_ctr #(.CW(CW)) u_md (
    .clk        (clk),
    .rst_n      (reset),
    .load_i     (md_load),
    .load_val_i (md_val),
    .busy_o     (md_busy)
  );

  assign E_ad = e_wa_q;
  assign M_ad = m_wa_q;
  assign W_ad = w_wa_q;

endmodule

// File: tb/tb_hazard_sb.sv
// Bench for hazard_sb: directed hazard scenarios plus random traffic
// checked against an issue-history model of the pipeline.
module tb_hazard_sb;
  import hazard_pkg::*;

  localparam int MULT_CYC = 5;
  localparam int DIV_CYC  = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  D_rs_a, D_rt_a, D_wa, E_rs_a, E_rt_a, M_rt_a;
  logic [1:0]  D_rs_tuse, D_rt_tuse, D_tnew, D_md_op;
  logic [31:0] D_rs_o, D_rt_o, E_rs_o, E_rt_o, M_rt_o;
  logic [31:0] E_wd, M_wd, W_wd;
  logic [31:0] D_rs_m, D_rt_m, E_rs_m, E_rt_m, M_rt_m;
  logic        stall, md_busy;
  logic [4:0]  E_ad, M_ad, W_ad;

  hazard_sb #(
    .XLEN(32), .TW(2), .MULT_CYC(MULT_CYC),
    .DIV_CYC(DIV_CYC), .CW(4)
  ) dut (
    .clk(clk), .reset(reset),
    .D_rs_a(D_rs_a), .D_rt_a(D_rt_a),
    .D_rs_tuse(D_rs_tuse), .D_rt_tuse(D_rt_tuse),
    .D_wa(D_wa), .D_tnew(D_tnew), .D_md_op(D_md_op),
    .E_rs_a(E_rs_a), .E_rt_a(E_rt_a), .M_rt_a(M_rt_a),
    .D_rs_o(D_rs_o), .D_rt_o(D_rt_o), .E_rs_o(E_rs_o),
    .E_rt_o(E_rt_o), .M_rt_o(M_rt_o),
    .E_wd(E_wd), .M_wd(M_wd), .W_wd(W_wd),
    .D_rs_m(D_rs_m), .D_rt_m(D_rt_m), .E_rs_m(E_rs_m),
    .E_rt_m(E_rt_m), .M_rt_m(M_rt_m),
    .stall(stall), .E_ad(E_ad), .M_ad(M_ad), .W_ad(W_ad),
    .md_busy(md_busy)
  );

  always #5 clk = ~clk;

  // Model: every issued instruction with the edge it issued on.
  // Age 0 = in E, 1 = in M, 2 = in W; result ready once age >= tnew.
  typedef struct {
    logic [4:0] wa;
    int         tnew;
    int         iss;
  } ins_t;

  ins_t q[$];
  int   cyc;
  int   md_end;
  bit   st_exp;
  int   checks;
  int   errors;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit src_hz(input logic [4:0] s, input int tuse);
    if (s == 5'd0) return 1'b0;
    foreach (q[i]) begin
      int age = cyc - q[i].iss;
      int rem = q[i].tnew - age;
      if (age <= 1 && q[i].wa == s && rem > tuse) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic logic [31:0] stage_wd(input int age);
    if (age == 0) return E_wd;
    if (age == 1) return M_wd;
    return W_wd;
  endfunction

  function automatic logic [31:0] exp_fwd(input logic [4:0] a,
                                          input int min_age,
                                          input logic [31:0] raw);
    if (a == 5'd0) return 32'd0;
    for (int age = min_age; age <= 2; age++)
      foreach (q[i])
        if (q[i].wa == a && cyc - q[i].iss == age)
          return stage_wd(age);
    return raw;
  endfunction

  function automatic logic [31:0] exp_ad(input int age);
    foreach (q[i])
      if (cyc - q[i].iss == age) return 32'(q[i].wa);
    return 32'd0;
  endfunction

  task automatic check_all();
    bit md_b = (cyc <= md_end);
    st_exp = src_hz(D_rs_a, int'(D_rs_tuse)) ||
             src_hz(D_rt_a, int'(D_rt_tuse)) ||
             (D_md_op != MD_NONE && md_b);
    chk("stall", 32'(stall), 32'(st_exp));
    chk("md_busy", 32'(md_busy), 32'(md_b));
    chk("E_ad", 32'(E_ad), exp_ad(0));
    chk("M_ad", 32'(M_ad), exp_ad(1));
    chk("W_ad", 32'(W_ad), exp_ad(2));
    chk("D_rs_m", D_rs_m, exp_fwd(D_rs_a, 0, D_rs_o));
    chk("D_rt_m", D_rt_m, exp_fwd(D_rt_a, 0, D_rt_o));
    chk("E_rs_m", E_rs_m, exp_fwd(E_rs_a, 1, E_rs_o));
    chk("E_rt_m", E_rt_m, exp_fwd(E_rt_a, 1, E_rt_o));
    chk("M_rt_m", M_rt_m, exp_fwd(M_rt_a, 2, M_rt_o));
  endtask

  task automatic model_edge();
    cyc++;
    if (!st_exp) begin
      q.push_back('{D_wa, int'(D_tnew), cyc});
      if (D_md_op == MD_MULT) md_end = cyc + MULT_CYC - 1;
      if (D_md_op == MD_DIV)  md_end = cyc + DIV_CYC - 1;
    end
    while (q.size() > 0 && cyc - q[0].iss > 2) void'(q.pop_front());
  endtask

  task automatic model_reset();
    q.delete();
    md_end = cyc - 1;
  endtask

  // Called at a falling edge with D inputs already driven.
  task automatic tick();
    #1;
    check_all();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic issue(input int maxc, output int n);
    n = 0;
    forever begin
      tick();
      if (!st_exp) break;
      n++;
      if (n > maxc) break;
    end
  endtask

  task automatic set_d(input int rs, input int rt, input int rsu,
                       input int rtu, input int wa, input int tn,
                       input logic [1:0] md);
    D_rs_a    = 5'(rs);
    D_rt_a    = 5'(rt);
    D_rs_tuse = 2'(rsu);
    D_rt_tuse = 2'(rtu);
    D_wa      = 5'(wa);
    D_tnew    = 2'(tn);
    D_md_op   = md;
  endtask

  task automatic randomize_data();
    D_rs_o = $urandom; D_rt_o = $urandom; E_rs_o = $urandom;
    E_rt_o = $urandom; M_rt_o = $urandom;
  endtask

  initial begin
    int n;
    checks = 0; errors = 0; cyc = 0; md_end = -1;
    reset = 1'b0;
    set_d(0, 0, 0, 0, 0, 0, MD_NONE);
    E_rs_a = 5'd1; E_rt_a = 5'd2; M_rt_a = 5'd3;
    E_wd = 32'hFFFF_FFFF; M_wd = 32'h1234; W_wd = 32'h5678;
    randomize_data();
    @(negedge clk);
    check_all();
    reset = 1'b1;

    // lw $1 then addu $2,$1,$1
    set_d(0, 0, 0, 0, 1, 2, MD_NONE); tick();
    set_d(1, 1, 0, 0, 2, 1, MD_NONE); issue(6, n);
    chk("lw_use_stalls", 32'(n), 32'd2);
    set_d(0, 0, 0, 0, 0, 0, MD_NONE);
    repeat (3) tick();

    // addu $1 then beq $1
    set_d(0, 0, 0, 0, 1, 1, MD_NONE); tick();
    set_d(1, 0, 0, 0, 0, 0, MD_NONE); issue(6, n);
    chk("alu_branch_stalls", 32'(n), 32'd1);
    set_d(0, 0, 0, 0, 0, 0, MD_NONE);
    repeat (3) tick();

    // write $0 then read $0
    set_d(0, 0, 0, 0, 0, 1, MD_NONE); tick();
    set_d(0, 0, 0, 0, 4, 0, MD_NONE);
    #1 chk("zero_src_fwd", D_rs_m, 32'd0);
    issue(6, n);
    chk("zero_src_stalls", 32'(n), 32'd0);

    // $3 in E and M, younger E wins
    set_d(0, 0, 0, 0, 3, 0, MD_NONE); tick();
    set_d(0, 0, 0, 0, 3, 0, MD_NONE); tick();
    set_d(0, 3, 0, 0, 0, 0, MD_NONE);
    #1 chk("younger_wins", D_rt_m, 32'hFFFF_FFFF);
    issue(6, n);
    chk("younger_stalls", 32'(n), 32'd0);

    // div then mfhi, mult then mflo
    set_d(0, 0, 0, 0, 0, 0, MD_DIV); tick();
    set_d(0, 0, 0, 0, 4, 0, MD_HILO); issue(15, n);
    chk("div_stalls", 32'(n), 32'(DIV_CYC));
    set_d(0, 0, 0, 0, 0, 0, MD_MULT); tick();
    set_d(0, 0, 0, 0, 5, 0, MD_HILO); issue(15, n);
    chk("mult_stalls", 32'(n), 32'(MULT_CYC));

    // reset mid-div with live tags
    set_d(0, 0, 0, 0, 0, 0, MD_DIV); tick();
    set_d(0, 0, 0, 0, 6, 2, MD_NONE);
    repeat (3) tick();
    reset = 1'b0;
    model_reset();
    #1;
    chk("rst_md_busy", 32'(md_busy), 32'd0);
    chk("rst_E_ad", 32'(E_ad), 32'd0);
    check_all();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    set_d(6, 0, 0, 0, 0, 0, MD_HILO); issue(15, n);
    chk("post_rst_stalls", 32'(n), 32'd0);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      int r = $urandom_range(0, 9);
      logic [1:0] md;
      md = (r == 0) ? MD_MULT : (r == 1) ? MD_DIV :
           (r == 2) ? MD_HILO : MD_NONE;
      set_d($urandom_range(0, 4), $urandom_range(0, 4),
            $urandom_range(0, 3), $urandom_range(0, 3),
            $urandom_range(0, 4), $urandom_range(0, 3), md);
      E_rs_a = 5'($urandom_range(0, 4));
      E_rt_a = 5'($urandom_range(0, 4));
      M_rt_a = 5'($urandom_range(0, 4));
      E_wd = $urandom; M_wd = $urandom; W_wd = $urandom;
      randomize_data();
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_sb.md
# hazard_sb

Scoreboard-based hazard unit for the five-stage pipeline: it owns the E/M/W destination-tag pipeline internally rather than receiving per-stage Tnew, and issues stall and forwarding selects from it. It adds a multiply/divide busy counter with separate mult/div latencies. It sits beside the D-stage decoder and drives the stall line for F/D and the D→E bubble, plus the operand forwarding muxes for D, E and M.

## Interface
Parameters:
- `XLEN`, 32, datapath width
- `TW`, 2, Tuse/Tnew field width
- `MULT_CYC`, 5, busy cycles after a mult/multu issue
- `DIV_CYC`, 10, busy cycles after a div/divu issue
- `CW`, 4, md counter width; must hold max(MULT_CYC, DIV_CYC)

Ports:
- `clk`  in  1  clock (one clock)
- `reset`  in  1  asynchronous, active-low reset
- `D_rs_a`, `D_rt_a`  in  5  D-stage source register numbers
- `D_rs_tuse`, `D_rt_tuse`  in  TW  cycles until D-stage operand is consumed (0 = in D)
- `D_wa`  in  5  D-stage destination (0 = none)
- `D_tnew`  in  TW  cycles after E entry until the result exists (0 = ready in E)
- `D_md_op`  in  2  `MD_NONE`, `MD_MULT`, `MD_DIV`, `MD_HILO`
- `E_rs_a`, `E_rt_a`, `M_rt_a`  in  5  source numbers held in pipeline regs
- `D_rs_o`, `D_rt_o`, `E_rs_o`, `E_rt_o`, `M_rt_o`  in  XLEN  unforwarded operands
- `E_wd`, `M_wd`, `W_wd`  in  XLEN  result data of each stage
- `D_rs_m`, `D_rt_m`, `E_rs_m`, `E_rt_m`, `M_rt_m`  out  XLEN  forwarded operands
- `stall`  out  1  hold PC and F/D, insert bubble into E
- `E_ad`, `M_ad`, `W_ad`  out  5  tracked destinations (debug/visibility)
- `md_busy`  out  1  md counter non-zero

## Operation
- Tag pipeline: per stage {wa, tnew}. Each edge: W ← {M.wa, 0}; M ← {E.wa, sat_dec(E.tnew)}; E ← stall ? {0, 0} : {D_wa, D_tnew}.
- Stall per source s in {rs, rt}, s ≠ 0: (E.wa == s && E.tnew > s_tuse) || (M.wa == s && M.tnew > s_tuse). W never stalls.
- md stall: D_md_op ≠ MD_NONE && md_busy.
- `stall` = rs stall | rt stall | md stall.
- Forwarding, any stage operand: number 0 → 0; else first match in E (D only), M (D, E), W (D, E, M) selects that stage's wd; else unforwarded input. Younger stage always wins. A matched but not-ready source is masked by `stall`, so its value is don't-care.
- md counter: on an edge where D_md_op is MD_MULT/MD_DIV and stall = 0, load MULT_CYC/DIV_CYC; else decrement if non-zero. A non-zero counter cannot be loaded because md stall blocks the issue.

## Timing
- Reset (async, `reset` low): all tags {0,0}, counter 0; E_ad = M_ad = W_ad = 0, md_busy = 0. Forwarded outputs equal unforwarded inputs and `stall` depends only on D inputs with zero tags (so 0).
- All outputs except tags/md_busy are combinational, same cycle as inputs.
- Tag and counter updates take effect one edge after D presents the instruction; E_ad shows D_wa the cycle after issue.
- mult issued at edge t → md_busy high for cycles t+1..t+MULT_CYC; dependent HI/LO op issues at edge t+MULT_CYC+1... i.e. stalls exactly MULT_CYC cycles.
- Reset deasserted mid-stream: pipeline restarts from empty tags; no stale stall.
- wa = 0 never causes stall or forward.

## Structure
- `hazard_pkg`: MD_* op encoding, TW default, sat_dec function.
- Sub-module `md_busy_ctr` (load value, decrement, busy flag); tag pipeline and forwarding stay in the top.

## Test plan
- lw $1 (tnew 2) then addu $2,$1,$1 (tuse 0) → stall 2 cycles, then D_rs_m = M_wd then W_wd as the lw moves; addu issues on the 3rd cycle.
- addu $1 (tnew 1) then beq $1 (tuse 0) → 1 stall; next cycle D_rs_m = M_wd = 0x1234.
- ori $0 then use $0 → no stall, D_rs_m = 0 despite E_wd = 0xFFFF_FFFF.
- $3 written in E and M simultaneously, E ready → D_rt_m = E_wd (younger wins).
- div then mfhi → stall exactly 10 cycles, md_busy 10 cycles; mult with MULT_CYC = 5 → 5 cycles.
- Assert reset mid-div (counter 7) → md_busy 0 and tags 0 immediately; mfhi issues without stall.
